// File: rtl/line_tracker_n.sv
// line_tracker_n: N-sensor infrared line-tracking controller.
// Each raw sensor bit is debounced. The filtered bits give a signed weighted line error, which is
// mapped to a servo code and a motor code. The controller adds a start-up drive delay, recovery
// by reversing when the car is stuck in a big turn, and end-of-track detection.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-low
//   ir             raw sensor bits, 1 = black, 0 = white; ir[N_IR-1] is outermost on the right
//   en_tracking    enable; low forces IDLE
//   front_wheel    000 straight, 001 L small, 011 L big, 101 R small, 111 R big
//   motor          00 stop, 01 forward, 10 backward, 11 fast forward
//   end_of_track   high in DONE
//   recovering     high in RECOVER
//   recover_count  recoveries since leaving IDLE, saturating at 255
module line_tracker_n #(
  parameter int unsigned N_IR         = 4,
  parameter int unsigned DEBOUNCE     = 2,
  parameter int unsigned SMALL_TH     = 2,
  parameter int unsigned TURN_DELAY   = 5,
  parameter int unsigned DRIVE_DELAY  = 8,
  parameter int unsigned LOST_TIMEOUT = 20,
  parameter int unsigned RECOVER_LEN  = 30,
  parameter int unsigned CW           = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IR-1:0] ir,
  input  logic            en_tracking,
  output logic [2:0]      front_wheel,
  output logic [1:0]      motor,
  output logic            end_of_track,
  output logic            recovering,
  output logic [7:0]      recover_count
);

  typedef enum logic [1:0] {StIdle, StTrack, StRecover, StDone} state_e;

  localparam logic [2:0] WheelStraight = 3'b000;
  localparam logic [2:0] WheelLSmall   = 3'b001;
  localparam logic [2:0] WheelLBig     = 3'b011;
  localparam logic [2:0] WheelRSmall   = 3'b101;
  localparam logic [2:0] WheelRBig     = 3'b111;

  localparam logic [1:0] MotorStop = 2'b00;
  localparam logic [1:0] MotorFwd  = 2'b01;
  localparam logic [1:0] MotorBack = 2'b10;
  localparam logic [1:0] MotorFast = 2'b11;

  localparam int unsigned Half = N_IR / 2;

  localparam logic signed [7:0] SmallTh    = 8'(SMALL_TH);
  localparam logic [CW-1:0]     DebounceLim = CW'(DEBOUNCE);
  localparam logic [CW-1:0]     TurnLim     = CW'(TURN_DELAY);
  localparam logic [CW-1:0]     DriveLim    = CW'(DRIVE_DELAY);
  localparam logic [CW-1:0]     LostLim     = CW'(LOST_TIMEOUT);
  // Last timer value of the reverse-driving phase.
  localparam logic [CW-1:0]     RecoverEnd  = CW'(DRIVE_DELAY + RECOVER_LEN - 1);

  function automatic logic signed [7:0] weight(input int unsigned idx);
    int w;
    if (idx >= Half) begin
      w = int'(idx) - int'(Half) + 1;
    end else begin
      w = int'(idx) - int'(Half);
    end
    return 8'(w);
  endfunction

  // Debounce filters.
  logic [N_IR-1:0] filt_q, filt_d;
  logic [CW-1:0]   db_cnt_q [N_IR];
  logic [CW-1:0]   db_cnt_d [N_IR];

  always_comb begin
    for (int unsigned i = 0; i < N_IR; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = '0;
      if (ir[i] != filt_q[i]) begin
        // The bit flips on the edge where the counter would reach DEBOUNCE.
        if (db_cnt_q[i] + CW'(1) >= DebounceLim) begin
          filt_d[i] = ir[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q   <= '0;
      db_cnt_q <= '{default: '0};
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Line error and steering map.
  logic signed [7:0] err;
  logic [2:0]        steer;
  logic              steer_big;
  logic              all_black;
  logic              all_white;

  always_comb begin
    err = '0;
    for (int unsigned i = 0; i < N_IR; i++) begin
      if (filt_q[i]) begin
        err = err + weight(i);
      end
    end
  end

  always_comb begin
    if (err == 8'sd0) begin
      steer = WheelStraight;
    end else if (err > 8'sd0) begin
      steer = (err > SmallTh) ? WheelRBig : WheelRSmall;
    end else begin
      steer = (err < -SmallTh) ? WheelLBig : WheelLSmall;
    end
  end

  assign steer_big = steer[1];
  assign all_black = &filt_q;
  assign all_white = ~|filt_q;

  // Control FSM.
  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d, timer_inc;
  logic [CW-1:0] big_q, big_d, big_inc;
  logic          dir_right_q, dir_right_d;
  logic          entering;
  logic [7:0]    rc_d;
  logic [2:0]    wheel_d;
  logic [1:0]    motor_d;
  logic          eot_d;
  logic          rec_d;

  always_comb begin
    state_d     = state_q;
    rc_d        = recover_count;
    dir_right_d = dir_right_q;
    big_d       = '0;
    wheel_d     = WheelStraight;
    motor_d     = MotorStop;
    eot_d       = 1'b0;
    rec_d       = 1'b0;

    if (!en_tracking) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StTrack;
        StTrack: begin
          if (all_black) begin
            state_d = StDone;
          end else if (big_q >= LostLim) begin
            state_d = StRecover;
            rc_d    = (&recover_count) ? recover_count : recover_count + 8'd1;
          end
        end
        StRecover: begin
          if (timer_q >= RecoverEnd) begin
            state_d = StTrack;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    entering  = (state_d != state_q);
    timer_inc = (&timer_q) ? timer_q : timer_q + CW'(1);
    big_inc   = (&big_q) ? big_q : big_q + CW'(1);
    timer_d   = (entering || state_d == StIdle || state_d == StDone) ? '0 : timer_inc;

    // Outputs are computed from the next state so they change on the entering edge.
    unique case (state_d)
      StIdle: rc_d = '0;
      StTrack: begin
        wheel_d = steer;
        if (timer_d < DriveLim) begin
          motor_d = MotorStop;
        end else begin
          motor_d = all_white ? MotorFast : MotorFwd;
        end
        if (steer_big) begin
          big_d       = entering ? CW'(1) : big_inc;
          dir_right_d = steer[2];
        end
      end
      StRecover: begin
        rec_d = 1'b1;
        if (timer_d < TurnLim) begin
          wheel_d = WheelStraight;
        end else begin
          wheel_d = dir_right_q ? WheelLBig : WheelRBig;
        end
        motor_d = (timer_d < DriveLim) ? MotorStop : MotorBack;
      end
      StDone:  eot_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      big_q         <= '0;
      dir_right_q   <= 1'b0;
      front_wheel   <= WheelStraight;
      motor         <= MotorStop;
      end_of_track  <= 1'b0;
      recovering    <= 1'b0;
      recover_count <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      big_q         <= big_d;
      dir_right_q   <= dir_right_d;
      front_wheel   <= wheel_d;
      motor         <= motor_d;
      end_of_track  <= eot_d;
      recovering    <= rec_d;
      recover_count <= rc_d;
    end
  end

endmodule

// File: tb/tb_line_tracker_n.sv
// Testbench for line_tracker_n with N_IR=6: scenario tasks compare the DUT against a cycle
// reference model derived from the behavioural rules, plus fixed expected values.
module tb_line_tracker_n;

  localparam int NIr  = 6;
  localparam int Db   = 2;
  localparam int Sm   = 2;
  localparam int Td   = 5;
  localparam int Dd   = 8;
  localparam int Lost = 20;
  localparam int Rl   = 30;
  localparam int TimerMax = (1 << 26) - 1;

  localparam int MIdle    = 0;
  localparam int MTrack   = 1;
  localparam int MRecover = 2;
  localparam int MDone    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NIr-1:0] ir;
  logic           en_tracking;
  logic [2:0]     front_wheel;
  logic [1:0]     motor;
  logic           end_of_track;
  logic           recovering;
  logic [7:0]     recover_count;

  int vectors     = 0;
  int miscompares = 0;

  line_tracker_n #(
    .N_IR(NIr), .DEBOUNCE(Db), .SMALL_TH(Sm), .TURN_DELAY(Td), .DRIVE_DELAY(Dd),
    .LOST_TIMEOUT(Lost), .RECOVER_LEN(Rl), .CW(26)
  ) dut (
    .clk(clk), .rst(rst), .ir(ir), .en_tracking(en_tracking), .front_wheel(front_wheel),
    .motor(motor), .end_of_track(end_of_track), .recovering(recovering),
    .recover_count(recover_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state.
  int           m_state, m_age, m_big, m_rc;
  bit           m_dir_right;
  bit [NIr-1:0] m_filt;
  int           m_run [NIr];
  logic [2:0]   m_wheel;
  logic [1:0]   m_motor;
  logic         m_eot, m_rec;

  function automatic int wgt(input int i);
    return (i >= NIr / 2) ? i - NIr / 2 + 1 : i - NIr / 2;
  endfunction

  function automatic logic [2:0] steer_of(input int e);
    if (e == 0) return 3'b000;
    if (e > 0) return (e > Sm) ? 3'b111 : 3'b101;
    return (e < -Sm) ? 3'b011 : 3'b001;
  endfunction

  function automatic logic [14:0] dut_word();
    return {front_wheel, motor, end_of_track, recovering, recover_count};
  endfunction

  function automatic logic [14:0] mdl_word();
    return {m_wheel, m_motor, m_eot, m_rec, 8'(m_rc)};
  endfunction

  task automatic model_reset();
    m_state = MIdle; m_age = 0; m_big = 0; m_rc = 0; m_dir_right = 0; m_filt = '0;
    for (int i = 0; i < NIr; i++) m_run[i] = 0;
    m_wheel = 3'b000; m_motor = 2'b00; m_eot = 0; m_rec = 0;
  endtask

  task automatic model_step(input logic [NIr-1:0] r, input logic e);
    int         err;
    int         nxt;
    logic [2:0] st;
    bit         is_big;
    bit         entering;
    err = 0;
    for (int i = 0; i < NIr; i++) if (m_filt[i]) err += wgt(i);
    st     = steer_of(err);
    is_big = (st == 3'b011) || (st == 3'b111);
    if (!e) nxt = MIdle;
    else begin
      case (m_state)
        MIdle:    nxt = MTrack;
        MTrack:   nxt = (&m_filt) ? MDone : (m_big >= Lost) ? MRecover : MTrack;
        MRecover: nxt = (m_age >= Dd + Rl - 1) ? MTrack : MRecover;
        default:  nxt = MDone;
      endcase
    end
    entering = (nxt != m_state);
    if (nxt == MIdle) m_rc = 0;
    else if (nxt == MRecover && entering && m_rc < 255) m_rc++;
    if (entering || nxt == MIdle || nxt == MDone) m_age = 0;
    else if (m_age < TimerMax) m_age++;
    if (nxt == MTrack && is_big) begin
      m_big       = entering ? 1 : m_big + 1;
      m_dir_right = (st == 3'b111);
    end else begin
      m_big = 0;
    end
    m_wheel = 3'b000; m_motor = 2'b00; m_eot = 0; m_rec = 0;
    case (nxt)
      MTrack: begin
        m_wheel = st;
        m_motor = (m_age < Dd) ? 2'b00 : (m_filt == '0) ? 2'b11 : 2'b01;
      end
      MRecover: begin
        m_rec   = 1;
        m_wheel = (m_age < Td) ? 3'b000 : (m_dir_right ? 3'b011 : 3'b111);
        m_motor = (m_age < Dd) ? 2'b00 : 2'b10;
      end
      MDone:   m_eot = 1;
      default: ;
    endcase
    m_state = nxt;
    for (int i = 0; i < NIr; i++) begin
      if (r[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] >= Db) begin
          m_filt[i] = r[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // Applies inputs away from the edge, steps the model with the edge, samples 1 time unit later.
  task automatic tick(input logic [NIr-1:0] r, input logic e);
    @(negedge clk);
    ir          = r;
    en_tracking = e;
    @(posedge clk);
    model_step(r, e);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ir = '0; en_tracking = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (dut_word() !== 15'h0) begin
      $display("FAIL reset_async: got %h want 0000", dut_word()); miscompares++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_word() !== 15'h0) begin
      $display("FAIL reset_held: got %h want 0000", dut_word()); miscompares++;
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    tick('0, 1'b0);
    vectors++;
    if (dut_word() !== 15'h0 || dut_word() !== mdl_word()) begin
      $display("FAIL reset_idle: got %h want %h", dut_word(), mdl_word()); miscompares++;
    end
  endtask

  task automatic test_drive_delay();
    for (int k = 1; k <= 12; k++) begin
      tick('0, 1'b1);
      vectors++;
      if (dut_word() !== mdl_word()) begin
        $display("FAIL drive_model k=%0d: got %h want %h", k, dut_word(), mdl_word());
        miscompares++;
      end
      vectors++;
      if (motor !== ((k <= Dd) ? 2'b00 : 2'b11) || front_wheel !== 3'b000) begin
        $display("FAIL drive_delay k=%0d: got motor=%b wheel=%b", k, motor, front_wheel);
        miscompares++;
      end
    end
  endtask

  task automatic test_steering();
    logic [NIr-1:0] pats   [8] = '{6'b100000, 6'b001000, 6'b000100, 6'b000011,
                                   6'b010000, 6'b000000, 6'b000001, 6'b011000};
    logic [2:0]     wheels [8] = '{3'b111, 3'b101, 3'b001, 3'b011,
                                   3'b101, 3'b000, 3'b011, 3'b111};
    for (int p = 0; p < 8; p++) begin
      for (int k = 1; k <= 5; k++) begin
        tick(pats[p], 1'b1);
        vectors++;
        if (dut_word() !== mdl_word()) begin
          $display("FAIL steer_model p=%0d k=%0d: got %h want %h", p, k, dut_word(), mdl_word());
          miscompares++;
        end
        if (k == 3) begin
          vectors++;
          if (front_wheel !== wheels[p]) begin
            $display("FAIL steer_map p=%0d: got %b want %b", p, front_wheel, wheels[p]);
            miscompares++;
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    repeat (4) tick('0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick((k % 2 == 0) ? 6'b100000 : 6'b000000, 1'b1);
      vectors++;
      if (front_wheel !== 3'b000 || dut_word() !== mdl_word()) begin
        $display("FAIL glitch k=%0d: got %h want %h", k, dut_word(), mdl_word());
        miscompares++;
      end
    end
  endtask

  task automatic enter_recover(input string tag);
    int n;
    n = 0;
    do begin
      tick(6'b110000, 1'b1);
      n++;
      vectors++;
      if (dut_word() !== mdl_word()) begin
        $display("FAIL %s_wait n=%0d: got %h want %h", tag, n, dut_word(), mdl_word());
        miscompares++;
      end
    end while (!recovering && n < 60);
    vectors++;
    if (!recovering) begin
      $display("FAIL %s_timeout: recovering=%b after %0d cycles, want 1", tag, recovering, n);
      miscompares++;
    end
  endtask

  task automatic test_recover();
    tick(6'b110000, 1'b0);
    enter_recover("recover");
    vectors++;
    if (recover_count !== 8'd1 || front_wheel !== 3'b000 || motor !== 2'b00) begin
      $display("FAIL recover_entry: got rc=%0d wheel=%b motor=%b want 1/000/00",
               recover_count, front_wheel, motor);
      miscompares++;
    end
    for (int k = 1; k <= 42; k++) begin
      tick(6'b110000, 1'b1);
      vectors++;
      if (dut_word() !== mdl_word()) begin
        $display("FAIL recover_model k=%0d: got %h want %h", k, dut_word(), mdl_word());
        miscompares++;
      end
      if (k < Dd + Rl) begin
        vectors++;
        if (recovering !== 1'b1 || front_wheel !== ((k < Td) ? 3'b000 : 3'b011) ||
            motor !== ((k < Dd) ? 2'b00 : 2'b10)) begin
          $display("FAIL recover_seq k=%0d: got rec=%b wheel=%b motor=%b",
                   k, recovering, front_wheel, motor);
          miscompares++;
        end
      end else if (k == Dd + Rl) begin
        vectors++;
        if (recovering !== 1'b0 || motor !== 2'b00 || recover_count !== 8'd1) begin
          $display("FAIL recover_exit: got rec=%b motor=%b rc=%0d want 0/00/1",
                   recovering, motor, recover_count);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_done_priority();
    int n;
    tick(6'b110000, 1'b0);
    n = 0;
    while (m_big != Lost - Db && n < 40) begin
      tick(6'b110000, 1'b1);
      n++;
      vectors++;
      if (dut_word() !== mdl_word()) begin
        $display("FAIL done_wait n=%0d: got %h want %h", n, dut_word(), mdl_word());
        miscompares++;
      end
    end
    // Filtered bits turn all-black on the edge where the big-turn counter reaches LOST_TIMEOUT.
    repeat (Db + 1) tick(6'b111111, 1'b1);
    vectors++;
    if (end_of_track !== 1'b1 || recovering !== 1'b0 || motor !== 2'b00 ||
        front_wheel !== 3'b000 || recover_count !== 8'd0 || dut_word() !== mdl_word()) begin
      $display("FAIL done_priority: got %h want %h", dut_word(), mdl_word());
      miscompares++;
    end
    for (int k = 0; k < 3; k++) begin
      tick(6'b000000, 1'b1);
      vectors++;
      if (end_of_track !== 1'b1 || dut_word() !== mdl_word()) begin
        $display("FAIL done_hold k=%0d: got %h want %h", k, dut_word(), mdl_word());
        miscompares++;
      end
    end
    tick(6'b000000, 1'b0);
    vectors++;
    if (end_of_track !== 1'b0 || dut_word() !== 15'h0) begin
      $display("FAIL done_exit: got %h want 0000", dut_word());
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_recover();
    tick(6'b110000, 1'b0);
    enter_recover("midrst");
    repeat (10) tick(6'b110000, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (dut_word() !== 15'h0) begin
      $display("FAIL midrst_async: got %h want 0000", dut_word()); miscompares++;
    end
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    en_tracking = 1'b0;
    ir          = '0;
    rst         = 1'b1;
    tick('0, 1'b1);
    vectors++;
    if (dut_word() !== mdl_word()) begin
      $display("FAIL midrst_restart: got %h want %h", dut_word(), mdl_word()); miscompares++;
    end
  endtask

  task automatic test_random();
    logic [NIr-1:0] pat;
    logic           en;
    int             hold;
    for (int seg = 0; seg < 400; seg++) begin
      pat  = ($urandom_range(0, 3) == 0) ? 6'b110000 : NIr'($urandom_range(0, 63));
      hold = $urandom_range(1, 8);
      en   = ($urandom_range(0, 30) != 0);
      for (int k = 0; k < hold; k++) begin
        tick(pat, en);
        vectors++;
        if (dut_word() !== mdl_word()) begin
          $display("FAIL random seg=%0d k=%0d ir=%b: got %h want %h",
                   seg, k, pat, dut_word(), mdl_word());
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_drive_delay();
    test_steering();
    test_glitch();
    test_recover();
    test_done_priority();
    test_reset_mid_recover();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
